// File: rtl/add_seq.sv
// Sequential W-bit adder that reuses one external 4-bit adder stage, one nibble per cycle, LSB first.
// Optional subtract mode (sub port, A + ~B + 1) is enabled by defining ADD_SEQ_SUB_EN.
module add_seq #(
    parameter int unsigned N_NIB = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*N_NIB-1:0]   op_a,
    input  logic [4*N_NIB-1:0]   op_b,
    input  logic                 cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_s,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*N_NIB-1:0]   sum,
    output logic                 cout,
    output logic                 ovf
);

    localparam int unsigned W     = 4 * N_NIB;
    localparam int unsigned IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;   // effective B: already inverted when subtracting
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic             b_inv;
    logic             c_init;

`ifdef ADD_SEQ_SUB_EN
    assign b_inv  = sub;
    assign c_init = sub ? 1'b1 : cin;
`else
    assign b_inv  = 1'b0;
    assign c_init = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign ovf       = (state == DONE) && (a_reg[W-1] == b_reg[W-1]) && (sum[W-1] != a_reg[W-1]);

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_cin = carry;
            for (int unsigned i = 0; i < N_NIB; i++) begin
                if (idx == IDX_W'(i)) begin
                    add_a = a_reg[4*i +: 4];
                    add_b = b_reg[4*i +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= op_a;
                        b_reg <= b_inv ? ~op_b : op_b;
                        carry <= c_init;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < N_NIB; i++) begin
                        if (idx == IDX_W'(i)) begin
                            sum[4*i +: 4] <= add_s;
                        end
                    end
                    carry <= add_cout;
                    if (idx == IDX_W'(N_NIB - 1)) begin
                        cout  <= add_cout;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_add_seq.sv
// Self-checking bench for add_seq (N_NIB=4) with a 4-bit adder model on the add_* ports.
// Define ADD_SEQ_SUB_EN on both DUT and bench to exercise subtract mode.
module tb_add_seq;

    localparam int unsigned N_NIB = 4;
    localparam int unsigned W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     op_a;
    logic [W-1:0]     op_b;
    logic             cin;
`ifdef ADD_SEQ_SUB_EN
    logic             sub;
`endif
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     sum;
    logic             cout;
    logic             ovf;
    logic [4:0]       add_res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // external 4-bit adder stage
    assign add_res  = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign add_s    = add_res[3:0];
    assign add_cout = add_res[4];

    add_seq #(.N_NIB(N_NIB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef ADD_SEQ_SUB_EN
        .sub(sub),
`endif
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_s(add_s), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    // Reference: {ovf, cout, sum} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic s);
        longint   sa, sb, sr;
        logic [W-1:0] r;
        logic     co;
        logic     ov;
        sa = longint'(a) - (a[W-1] ? (longint'(1) << W) : longint'(0));
        sb = longint'(b) - (b[W-1] ? (longint'(1) << W) : longint'(0));
        if (s) begin
            r  = a - b;
            co = (a >= b);
            sr = sa - sb;
        end else begin
            {co, r} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            sr = sa + sb + longint'(c);
        end
        ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
        return {ov, co, r};
    endfunction

    // Offers one operand set in an IDLE cycle and waits for DONE; leaves the DUT in DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         output logic [W+1:0] res, output int lat,
                         output logic [N_NIB-1:0] ctrace, output logic to);
        @(negedge clk);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        lat = 0; to = 1'b1; ctrace = '0;
        while (lat < 20 && to) begin
            @(negedge clk);
            if (out_valid) to = 1'b0;
            else begin
                if (lat < N_NIB) ctrace[lat] = add_cin;
                lat++;
            end
        end
        res = {ovf, cout, sum};
    endtask

    task automatic release_done();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        n_checks++;
        if ({add_a, add_b, add_cin} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_adder_port: got %h, want 000", {add_a, add_b, add_cin});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'h7FFF};
        logic [W-1:0] vb [3] = '{16'h1111, 16'h0001, 16'h0000};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W+1:0] ve [3] = '{{1'b0, 1'b0, 16'h2345}, {1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}};
        logic [W+1:0] res;
        logic [N_NIB-1:0] tr;
        logic to;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], res, lat, tr, to);
            n_checks++;
            if (to !== 1'b0) begin
                n_fail++;
                $display("FAIL directed%0d_timeout: out_valid not seen within 20 cycles", i);
            end
            // RUN cycles seen before out_valid; accept edge + N_NIB = N_NIB+1 edges
            n_checks++;
            if (lat !== N_NIB) begin
                n_fail++;
                $display("FAIL directed%0d_latency: got %0d RUN cycles, want %0d", i, lat, N_NIB);
            end
            n_checks++;
            if (res !== ve[i]) begin
                n_fail++;
                $display("FAIL directed%0d_result: got ovf,cout,sum=%h, want %h", i, res, ve[i]);
            end
            if (i == 1) begin
                n_checks++;
                if (tr !== 4'b1110) begin
                    n_fail++;
                    $display("FAIL carry_chain_trace: got add_cin per nibble=%b, want 1110", tr);
                end
            end
            release_done();
        end
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] res, exp;
        logic [N_NIB-1:0] tr;
        logic to;
        logic [W-1:0] a, b;
        logic c, s;
        int lat;
        for (int i = 0; i < 25; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            if (i % 5 == 0) b = ~a;
`ifdef ADD_SEQ_SUB_EN
            s = 1'($urandom);
            sub = s;
`else
            s = 1'b0;
`endif
            exp = model(a, b, c, s);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b%0d_ready: in_ready=%b in first IDLE cycle, want 1", i, in_ready);
            end
            do_op(a, b, c, res, lat, tr, to);
            n_checks++;
            if (to !== 1'b0 || lat !== N_NIB || res !== exp) begin
                n_fail++;
                $display("FAIL b2b%0d_result: a=%h b=%h c=%b s=%b got %h lat=%0d to=%b, want %h lat=%0d",
                         i, a, b, c, s, res, lat, to, exp, N_NIB);
            end
            release_done();
        end
`ifdef ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
    endtask

    task automatic test_hold_done();
        logic [W+1:0] res, exp;
        logic [N_NIB-1:0] tr;
        logic to;
        int lat;
        int bad;
        exp = model(16'hA5C3, 16'h3C5A, 1'b1, 1'b0);
        do_op(16'hA5C3, 16'h3C5A, 1'b1, res, lat, tr, to);
        n_checks++;
        if (res !== exp || to !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_result: got %h to=%b, want %h", res, to, exp);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ({out_valid, in_ready, ovf, cout, sum} !== {1'b1, 1'b0, exp}) bad++;
            in_valid = 1'b1; op_a = W'($urandom); op_b = W'($urandom);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: %0d of 10 DONE cycles changed outputs, want 0", bad);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, ovf, cout, sum} !== {1'b1, exp}) begin
            n_fail++;
            $display("FAIL hold_ignore_in_valid: got vld=%b res=%h, want 1 %h", out_valid, {ovf, cout, sum}, exp);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL hold_release: got rdy,vld=%b, want 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_abort();
        logic [W+1:0] res, exp;
        logic [N_NIB-1:0] tr;
        logic to;
        int lat;
        int seen;
        @(negedge clk);
        op_a = 16'h9ABC; op_b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b, want 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        n_checks++;
        if ({add_a, add_b, add_cin} !== 9'h000) begin
            n_fail++;
            $display("FAIL abort_adder_port: got %h, want 000", {add_a, add_b, add_cin});
        end
        // out_ready in IDLE must not disturb anything
        seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL abort_no_valid: %0d idle cycles had out_valid or lost in_ready, want 0", seen);
        end
        exp = model(16'h0F0F, 16'hF0F1, 1'b0, 1'b0);
        do_op(16'h0F0F, 16'hF0F1, 1'b0, res, lat, tr, to);
        n_checks++;
        if (res !== exp || lat !== N_NIB || to !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_new_op: got %h lat=%0d to=%b, want %h lat=%0d", res, lat, to, exp, N_NIB);
        end
        release_done();
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_sub();
        logic [W+1:0] res;
        logic [N_NIB-1:0] tr;
        logic to;
        int lat;
        sub = 1'b1;
        do_op(16'h0005, 16'h0007, 1'b0, res, lat, tr, to);
        n_checks++;
        if (res !== {1'b0, 1'b0, 16'hFFFE} || to !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_5_minus_7: got %h to=%b, want %h", res, to, {1'b0, 1'b0, 16'hFFFE});
        end
        release_done();
        do_op(16'h8000, 16'h0001, 1'b0, res, lat, tr, to);
        n_checks++;
        if (res !== {1'b1, 1'b1, 16'h7FFF} || to !== 1'b0) begin
            n_fail++;
            $display("FAIL sub_min_minus_1: got %h to=%b, want %h", res, to, {1'b1, 1'b1, 16'h7FFF});
        end
        release_done();
        sub = 1'b0;
    endtask
`endif

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0;
        op_a = '0; op_b = '0;
`ifdef ADD_SEQ_SUB_EN
        sub = 1'b0;
`endif
        test_reset();
        test_directed();
        test_hold_done();
        test_reset_abort();
        test_back_to_back();
`ifdef ADD_SEQ_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
